mul_sched: RTL and testbench

MUL_SCHED -- requirements
Module: mul_sched

---
 rtl/mul_sched_pkg.sv | 22 ++
 rtl/mul_req_fifo.sv | 69 ++++++
 rtl/mul_sched.sv | 147 ++++++++++++++
 tb/tb_mul_sched.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/mul_sched_pkg.sv
// Shared definitions for the multiply scheduler: FSM encoding and the
// operation bundle carried from the issue slots to the multiplier.
package mul_sched_pkg;

  localparam int SINGLE_WORD = 32;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2
  } mul_state_t;

  typedef struct packed {
    logic                     is_signed;
    logic                     acc;
    logic                     addsub;
    logic [2*SINGLE_WORD-1:0] opnd;
  } mul_op_t;

  localparam int MUL_OP_W = $bits(mul_op_t);

endpackage

// File: rtl/mul_req_fifo.sv
// In-order request queue with two write ports (slot 0 lands first) and one
// pop port. Pointers wrap modulo DEPTH; the count separates full from empty.
module mul_req_fifo
  import mul_sched_pkg::*;
#(
  parameter int DEPTH = 2,
  parameter int TAGW  = 4,
  localparam int PW   = $clog2(DEPTH),
  localparam int CW   = PW + 1
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            push0,
  input  mul_op_t         op0,
  input  logic [TAGW-1:0] tag0,
  input  logic            push1,
  input  mul_op_t         op1,
  input  logic [TAGW-1:0] tag1,
  input  logic            pop,
  output mul_op_t         head_op,
  output logic [TAGW-1:0] head_tag,
  output logic [CW-1:0]   count
);

  mul_op_t         op_mem  [DEPTH];
  logic [TAGW-1:0] tag_mem [DEPTH];
  logic [PW-1:0]   wr_ptr;
  logic [PW-1:0]   rd_ptr;
  logic [PW-1:0]   wr_ptr1;
  logic [1:0]      n_push;

  // Slot 1 goes behind slot 0 only when slot 0 is also pushing.
  assign wr_ptr1 = push0 ? wr_ptr + 1'b1 : wr_ptr;
  assign n_push  = {1'b0, push0} + {1'b0, push1};

  assign head_op  = op_mem[rd_ptr];
  assign head_tag = tag_mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (!flush) begin
      if (push0) begin
        op_mem[wr_ptr]  <= op0;
        tag_mem[wr_ptr] <= tag0;
      end
      if (push1) begin
        op_mem[wr_ptr1]  <= op1;
        tag_mem[wr_ptr1] <= tag1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      wr_ptr <= wr_ptr + PW'(n_push);
      if (pop) rd_ptr <= rd_ptr + 1'b1;
      count <= count + CW'(n_push) - CW'(pop);
    end
  end

endmodule

// File: rtl/mul_sched.sv
// Multiply scheduler: queues requests from two issue slots and feeds them to
// the multiplier one at a time, owning the architectural HI/LO pair.
module mul_sched
  import mul_sched_pkg::*;
#(
  parameter int QDEPTH = 2,
  parameter int TAGW   = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     req0_valid,
  output logic                     req0_ready,
  input  logic                     req0_signed,
  input  logic                     req0_acc,
  input  logic                     req0_addsub,
  input  logic [2*SINGLE_WORD-1:0] req0_opnd,
  input  logic [TAGW-1:0]          req0_tag,
  input  logic                     req1_valid,
  output logic                     req1_ready,
  input  logic                     req1_signed,
  input  logic                     req1_acc,
  input  logic                     req1_addsub,
  input  logic [2*SINGLE_WORD-1:0] req1_opnd,
  input  logic [TAGW-1:0]          req1_tag,
  input  logic                     cancel,
  output logic                     mul_req,
  output logic                     mul_signed,
  output logic                     mul_acc,
  output logic                     mul_addsub,
  output logic [2*SINGLE_WORD-1:0] mul_opnd,
  output logic                     mul_cancel,
  input  logic                     mul_opnd_ok,
  input  logic                     mul_data_ok,
  input  logic [2*SINGLE_WORD-1:0] mul_res,
  output logic [2*SINGLE_WORD-1:0] hilo_data,
  input  logic                     wr_hi,
  input  logic                     wr_lo,
  input  logic [SINGLE_WORD-1:0]   wr_data,
  output logic                     hilo_busy,
  output logic                     done_valid,
  output logic [TAGW-1:0]          done_tag,
  output logic [2*SINGLE_WORD-1:0] done_res
);

  localparam int CW = $clog2(QDEPTH) + 1;
  localparam logic [CW-1:0] DEPTH_C  = CW'(QDEPTH);
  localparam logic [CW-1:0] DEPTH_M2 = CW'(QDEPTH - 2);

  mul_state_t             state;
  logic [CW-1:0]          count;
  mul_op_t                op0, op1, head_op;
  logic [TAGW-1:0]        head_tag, tag_q;
  logic [SINGLE_WORD-1:0] hi, lo;
  logic                   push0, push1, pop, nonempty_next;

  // Readiness uses the current count only; a same-cycle pop frees no slot.
  assign req0_ready = !cancel && (count < DEPTH_C);
  assign req1_ready = !cancel && (req0_valid ? (count <= DEPTH_M2) : (count < DEPTH_C));
  assign push0 = req0_valid && req0_ready;
  assign push1 = req1_valid && req1_ready;
  assign pop   = (state == ST_ISSUE) && mul_opnd_ok && !cancel;
  assign nonempty_next = (count != '0) || push0 || push1;

  assign op0 = '{is_signed: req0_signed, acc: req0_acc, addsub: req0_addsub, opnd: req0_opnd};
  assign op1 = '{is_signed: req1_signed, acc: req1_acc, addsub: req1_addsub, opnd: req1_opnd};

  mul_req_fifo #(.DEPTH(QDEPTH), .TAGW(TAGW)) u_fifo (
    .clk      (clk),
    .rst      (rst),
    .flush    (cancel),
    .push0    (push0),
    .op0      (op0),
    .tag0     (req0_tag),
    .push1    (push1),
    .op1      (op1),
    .tag1     (req1_tag),
    .pop      (pop),
    .head_op  (head_op),
    .head_tag (head_tag),
    .count    (count)
  );

  assign mul_signed = head_op.is_signed;
  assign mul_acc    = head_op.acc;
  assign mul_addsub = head_op.addsub;
  assign mul_opnd   = head_op.opnd;
  assign mul_cancel = cancel;
  assign hilo_data  = {hi, lo};
  assign hilo_busy  = (count != '0) || (state != ST_IDLE);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= ST_IDLE;
      mul_req    <= 1'b0;
      tag_q      <= '0;
      hi         <= '0;
      lo         <= '0;
      done_valid <= 1'b0;
      done_tag   <= '0;
      done_res   <= '0;
    end else begin
      done_valid <= 1'b0;
      // Software writes only land while nothing is queued or in flight.
      if (!hilo_busy && wr_hi) hi <= wr_data;
      if (!hilo_busy && wr_lo) lo <= wr_data;
      if (cancel) begin
        state   <= ST_IDLE;
        mul_req <= 1'b0;
      end else begin
        case (state)
          ST_IDLE: begin
            if (count != '0) begin
              state   <= ST_ISSUE;
              mul_req <= 1'b1;
            end
          end
          ST_ISSUE: begin
            if (mul_opnd_ok) begin
              tag_q   <= head_tag;
              state   <= ST_WAIT;
              mul_req <= 1'b0;
            end
          end
          ST_WAIT: begin
            if (mul_data_ok) begin
              {hi, lo}   <= mul_res;
              done_valid <= 1'b1;
              done_tag   <= tag_q;
              done_res   <= mul_res;
              if (nonempty_next) begin
                state   <= ST_ISSUE;
                mul_req <= 1'b1;
              end else begin
                state <= ST_IDLE;
              end
            end
          end
          default: begin
            state   <= ST_IDLE;
            mul_req <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_mul_sched.sv
// Directed bench for mul_sched; the multiplier is played by hand-driven
// handshakes with precomputed results.
module tb_mul_sched;
  import mul_sched_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        req0_valid, req0_ready, req0_signed, req0_acc, req0_addsub;
  logic [63:0] req0_opnd;
  logic [3:0]  req0_tag;
  logic        req1_valid, req1_ready, req1_signed, req1_acc, req1_addsub;
  logic [63:0] req1_opnd;
  logic [3:0]  req1_tag;
  logic        cancel;
  logic        mul_req, mul_signed, mul_acc, mul_addsub, mul_cancel;
  logic [63:0] mul_opnd;
  logic        mul_opnd_ok, mul_data_ok;
  logic [63:0] mul_res;
  logic [63:0] hilo_data;
  logic        wr_hi, wr_lo;
  logic [31:0] wr_data;
  logic        hilo_busy, done_valid;
  logic [3:0]  done_tag;
  logic [63:0] done_res;

  int vectors = 0;
  int miscompares = 0;
  int illegal_wr = 0;

  always #5 clk = ~clk;

  mul_sched #(.QDEPTH(2), .TAGW(4)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_signed(req0_signed),
    .req0_acc(req0_acc), .req0_addsub(req0_addsub), .req0_opnd(req0_opnd), .req0_tag(req0_tag),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_signed(req1_signed),
    .req1_acc(req1_acc), .req1_addsub(req1_addsub), .req1_opnd(req1_opnd), .req1_tag(req1_tag),
    .cancel(cancel),
    .mul_req(mul_req), .mul_signed(mul_signed), .mul_acc(mul_acc), .mul_addsub(mul_addsub),
    .mul_opnd(mul_opnd), .mul_cancel(mul_cancel),
    .mul_opnd_ok(mul_opnd_ok), .mul_data_ok(mul_data_ok), .mul_res(mul_res),
    .hilo_data(hilo_data), .wr_hi(wr_hi), .wr_lo(wr_lo), .wr_data(wr_data),
    .hilo_busy(hilo_busy), .done_valid(done_valid), .done_tag(done_tag), .done_res(done_res)
  );

  // Requester-side protocol monitor: HI/LO writes must not arrive while busy.
  always @(posedge clk) begin
    if (rst && (wr_hi || wr_lo) && hilo_busy) illegal_wr++;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic wait_req(input string tag);
    for (int i = 0; i < 20; i++) begin
      if (mul_req) break;
      tick();
    end
    chk(tag, {63'd0, mul_req}, 64'd1);
  endtask

  initial begin
    rst = 1'b0;
    req0_valid = 0; req0_signed = 0; req0_acc = 0; req0_addsub = 0; req0_opnd = '0; req0_tag = '0;
    req1_valid = 0; req1_signed = 0; req1_acc = 0; req1_addsub = 0; req1_opnd = '0; req1_tag = '0;
    cancel = 0; mul_opnd_ok = 0; mul_data_ok = 0; mul_res = '0;
    wr_hi = 0; wr_lo = 0; wr_data = '0;
    #12;
    chk("rst_hilo", hilo_data, 64'd0);
    chk("rst_done_valid", {63'd0, done_valid}, 64'd0);
    chk("rst_mul_req", {63'd0, mul_req}, 64'd0);
    chk("rst_busy", {63'd0, hilo_busy}, 64'd0);
    chk("rst_ready0", {63'd0, req0_ready}, 64'd1);
    rst = 1'b1;
    tick();

    // Single unsigned 3*5, tag 1
    req0_valid = 1; req0_opnd = {32'd5, 32'd3}; req0_tag = 4'd1;
    tick();
    req0_valid = 0;
    chk("t1_no_early_req", {63'd0, mul_req}, 64'd0);
    chk("t1_busy", {63'd0, hilo_busy}, 64'd1);
    wait_req("t1_req");
    chk("t1_opnd", mul_opnd, {32'd5, 32'd3});
    chk("t1_signed", {63'd0, mul_signed}, 64'd0);
    mul_opnd_ok = 1;
    tick();
    mul_opnd_ok = 0;
    chk("t1_req_dropped", {63'd0, mul_req}, 64'd0);
    mul_data_ok = 1; mul_res = 64'hF;
    tick();
    mul_data_ok = 0;
    chk("t1_hilo", hilo_data, 64'hF);
    chk("t1_done_valid", {63'd0, done_valid}, 64'd1);
    chk("t1_done_tag", {60'd0, done_tag}, 64'd1);
    chk("t1_done_res", done_res, 64'hF);
    tick();
    chk("t1_done_pulse", {63'd0, done_valid}, 64'd0);
    chk("t1_idle", {63'd0, hilo_busy}, 64'd0);

    // Dual issue: signed -2*3 then MADD 1*1
    req0_valid = 1; req0_signed = 1; req0_acc = 0; req0_addsub = 0;
    req0_opnd = {32'd3, 32'hFFFF_FFFE}; req0_tag = 4'd2;
    req1_valid = 1; req1_signed = 1; req1_acc = 1; req1_addsub = 1;
    req1_opnd = {32'd1, 32'd1}; req1_tag = 4'd3;
    #1;
    chk("t2_ready0", {63'd0, req0_ready}, 64'd1);
    chk("t2_ready1", {63'd0, req1_ready}, 64'd1);
    tick();
    req0_valid = 0; req1_valid = 0;
    chk("t2_full_ready0", {63'd0, req0_ready}, 64'd0);
    wait_req("t2_req_a");
    chk("t2_opnd_a", mul_opnd, {32'd3, 32'hFFFF_FFFE});
    chk("t2_acc_a", {63'd0, mul_acc}, 64'd0);
    mul_opnd_ok = 1;
    tick();
    mul_opnd_ok = 0;
    mul_data_ok = 1; mul_res = 64'hFFFF_FFFF_FFFF_FFFA;
    tick();
    mul_data_ok = 0;
    chk("t2_hilo_a", hilo_data, 64'hFFFF_FFFF_FFFF_FFFA);
    chk("t2_tag_a", {60'd0, done_tag}, 64'd2);
    chk("t2_req_b", {63'd0, mul_req}, 64'd1);
    chk("t2_acc_b", {62'd0, mul_acc, mul_addsub}, 64'd3);
    mul_opnd_ok = 1;
    tick();
    mul_opnd_ok = 0;
    mul_data_ok = 1; mul_res = 64'hFFFF_FFFF_FFFF_FFFB;
    tick();
    mul_data_ok = 0;
    chk("t2_hilo_b", hilo_data, 64'hFFFF_FFFF_FFFF_FFFB);
    chk("t2_tag_b", {60'd0, done_tag}, 64'd3);
    tick();

    // Fill the queue while in WAIT, then cancel against a completing result
    req0_valid = 1; req0_signed = 0; req0_acc = 0; req0_addsub = 0; req0_opnd = {32'd7, 32'd7}; req0_tag = 4'd4;
    req1_valid = 1; req1_signed = 0; req1_acc = 0; req1_addsub = 0; req1_opnd = {32'd8, 32'd8}; req1_tag = 4'd5;
    tick();
    req0_valid = 0; req1_valid = 0;
    wait_req("t3_req_4");
    mul_opnd_ok = 1;
    tick();
    mul_opnd_ok = 0;
    req0_valid = 1; req0_tag = 4'd6;
    #1;
    chk("t3_ready1_yields", {63'd0, req1_ready}, 64'd0);
    chk("t3_ready0_one_free", {63'd0, req0_ready}, 64'd1);
    tick();
    req1_valid = 1; req0_tag = 4'd9; req1_tag = 4'd10;
    #1;
    chk("t3_full_ready0", {63'd0, req0_ready}, 64'd0);
    chk("t3_full_ready1", {63'd0, req1_ready}, 64'd0);
    tick();
    chk("t3_full_hold", {62'd0, req0_ready, req1_ready}, 64'd0);
    req0_valid = 0; req1_valid = 0;
    mul_data_ok = 1; mul_res = 64'h1111_2222_3333_4444;
    tick();
    mul_data_ok = 0;
    chk("t3_tag4_done", {60'd0, done_tag}, 64'd4);
    chk("t3_still_full", {63'd0, req0_ready}, 64'd0);
    mul_opnd_ok = 1;
    tick();
    mul_opnd_ok = 0;
    chk("t3_after_pop", {63'd0, req0_ready}, 64'd1);
    cancel = 1; mul_data_ok = 1; mul_res = 64'hDEAD_BEEF_DEAD_BEEF;
    #1;
    chk("t3_cancel_ready", {63'd0, req0_ready}, 64'd0);
    chk("t3_mul_cancel", {63'd0, mul_cancel}, 64'd1);
    tick();
    cancel = 0; mul_data_ok = 0;
    chk("t3_cancel_hilo", hilo_data, 64'h1111_2222_3333_4444);
    chk("t3_cancel_done", {63'd0, done_valid}, 64'd0);
    chk("t3_cancel_idle", {63'd0, hilo_busy}, 64'd0);
    tick();
    tick();
    chk("t3_cancel_no_req", {63'd0, mul_req}, 64'd0);

    // MTHI / MTLO while idle, then an ignored MTHI while busy
    wr_hi = 1; wr_data = 32'h1234_5678;
    tick();
    wr_hi = 0;
    chk("t4_wr_hi", hilo_data, 64'h1234_5678_3333_4444);
    wr_lo = 1; wr_data = 32'hABCD_0000;
    tick();
    wr_lo = 0;
    chk("t4_wr_lo", hilo_data, 64'h1234_5678_ABCD_0000);
    req0_valid = 1; req0_opnd = {32'd2, 32'd2}; req0_tag = 4'd7;
    tick();
    req0_valid = 0;
    wr_hi = 1; wr_data = 32'hFFFF_FFFF;
    tick();
    wr_hi = 0;
    chk("t4_busy_wr_ignored", hilo_data, 64'h1234_5678_ABCD_0000);
    chk("t4_busy_wr_flagged", 64'(illegal_wr), 64'd1);

    // Reset while WAIT, then a stray completion
    wait_req("t5_req");
    mul_opnd_ok = 1;
    tick();
    mul_opnd_ok = 0;
    chk("t5_busy", {63'd0, hilo_busy}, 64'd1);
    #2 rst = 1'b0;
    #1;
    chk("t5_rst_hilo", hilo_data, 64'd0);
    chk("t5_rst_outs", {60'd0, mul_req, done_valid, hilo_busy, |done_tag}, 64'd0);
    #2 rst = 1'b1;
    mul_data_ok = 1; mul_res = 64'd5;
    tick();
    mul_data_ok = 0;
    chk("t5_no_done", {63'd0, done_valid}, 64'd0);
    chk("t5_hilo_zero", hilo_data, 64'd0);
    tick();
    chk("t5_still_idle", {62'd0, mul_req, hilo_busy}, 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
